uart_tx: RTL and testbench

Buffered UART transmitter: 8 data bits, one start bit, one stop bit, no parity, LSB first. It is the transmit-side counterpart of the design's UART receiver and shares its `CLKS_PER_BIT` convention, so one parameter value sets both directions to the same baud rate. Bytes are pushed through a valid/ready handshake into a small internal FIFO, and the block drains that FIFO onto the serial line back-to-back. Host-side logic can therefore queue a short burst without waiting on each frame.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_tx_fifo.sv | 73 +++++++
 rtl/uart_tx.sv | 165 ++++++++++++++++
 tb/tb_uart_tx.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry and FSM state encodings.
// The receiver uses the same state type, which is why the encoding is 3 bits wide.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        s_IDLE         = 3'b000,
        s_TX_START_BIT = 3'b001,
        s_TX_DATA_BITS = 3'b010,
        s_TX_STOP_BIT  = 3'b011,
        s_CLEANUP      = 3'b100
    } uart_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO in front of the transmitter: registered count, combinational head read.
// Full is derived from the registered count only, so a push on a full FIFO is refused even if a pop happens in the same cycle.
module uart_tx_fifo #(
    parameter int FIFO_DEPTH = 4,
    parameter int WIDTH      = 8
) (
    input  logic                          i_Clock,
    input  logic                          i_Reset,
    input  logic                          i_Push,
    input  logic [WIDTH-1:0]              i_Wr_Data,
    input  logic                          i_Pop,
    output logic [WIDTH-1:0]              o_Rd_Data,
    output logic                          o_Full,
    output logic                          o_Empty,
    output logic [$clog2(FIFO_DEPTH):0]   o_Count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [WIDTH-1:0] mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign o_Full    = (count_q == CNT_W'(FIFO_DEPTH));
    assign o_Empty   = (count_q == '0);
    assign o_Count   = count_q;
    assign o_Rd_Data = mem_q[rd_ptr_q];

    assign push_ok = i_Push && !o_Full;
    assign pop_ok  = i_Pop && !o_Empty;

    // Pointers wrap naturally because the depth is a power of two.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = i_Wr_Data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// Buffered 8N1 UART transmitter: valid/ready pushes into a small FIFO, drained back-to-back onto a registered serial line.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 35,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          i_Clock,
    input  logic                          i_Reset,
    input  logic                          i_Tx_DV,
    input  logic [7:0]                    i_Tx_Byte,
    output logic                          o_Tx_Ready,
    output logic                          o_Tx_Serial,
    output logic                          o_Tx_Active,
    output logic                          o_Tx_Done,
    output logic [$clog2(FIFO_DEPTH):0]   o_Fifo_Count
);

    // state          | meaning
    // s_IDLE         | line high; pops the FIFO head when one is queued
    // s_TX_START_BIT | line low for one bit time
    // s_TX_DATA_BITS | shift[0] on the line, LSB first, 8 bits
    // s_TX_STOP_BIT  | line high for one bit time; done on its last cycle

    localparam int                 CNT_W    = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CNT_W-1:0]   CLK_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]         BIT_LAST = 3'(UART_DATA_BITS - 1);

    uart_state_e                 state_q, state_d;
    logic [CNT_W-1:0]            clk_cnt_q, clk_cnt_d;
    logic [2:0]                  bit_idx_q, bit_idx_d;
    logic [UART_DATA_BITS-1:0]   shift_q, shift_d;
    logic                        serial_q, serial_d;
    logic                        active_q, active_d;
    logic                        done_q, done_d;

    logic                        fifo_push;
    logic                        fifo_pop;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic [7:0]                  fifo_rd_data;
    logic                        bit_end;

    assign o_Tx_Ready  = !fifo_full;
    assign fifo_push   = i_Tx_DV && o_Tx_Ready;
    assign bit_end     = (clk_cnt_q == CLK_LAST);

    assign o_Tx_Serial = serial_q;
    assign o_Tx_Active = active_q;
    assign o_Tx_Done   = done_q;

    uart_tx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .WIDTH      (8)
    ) u_fifo (
        .i_Clock    (i_Clock),
        .i_Reset    (i_Reset),
        .i_Push     (fifo_push),
        .i_Wr_Data  (i_Tx_Byte),
        .i_Pop      (fifo_pop),
        .o_Rd_Data  (fifo_rd_data),
        .o_Full     (fifo_full),
        .o_Empty    (fifo_empty),
        .o_Count    (o_Fifo_Count)
    );

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state_q   <= s_IDLE;
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            serial_q  <= 1'b1;
            active_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            serial_q  <= serial_d;
            active_q  <= active_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        fifo_pop  = 1'b0;
        case (state_q)
            s_IDLE: begin
                clk_cnt_d = '0;
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    shift_d   = fifo_rd_data;
                    bit_idx_d = '0;
                    state_d   = s_TX_START_BIT;
                end
            end
            s_TX_START_BIT: begin
                if (bit_end) begin
                    clk_cnt_d = '0;
                    state_d   = s_TX_DATA_BITS;
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
            s_TX_DATA_BITS: begin
                if (bit_end) begin
                    clk_cnt_d = '0;
                    shift_d   = shift_q >> 1;
                    if (bit_idx_q == BIT_LAST) begin
                        state_d = s_TX_STOP_BIT;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
            s_TX_STOP_BIT: begin
                if (bit_end) begin
                    clk_cnt_d = '0;
                    state_d   = s_IDLE;
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d   = s_IDLE;
                clk_cnt_d = '0;
                bit_idx_d = '0;
            end
        endcase
    end

    // Outputs are registered, so the line trails the state register by one cycle.
    always_comb begin
        serial_d = 1'b1;
        active_d = 1'b0;
        done_d   = 1'b0;
        case (state_q)
            s_TX_START_BIT: begin
                serial_d = 1'b0;
                active_d = 1'b1;
            end
            s_TX_DATA_BITS: begin
                serial_d = shift_q[0];
                active_d = 1'b1;
            end
            s_TX_STOP_BIT: begin
                serial_d = 1'b1;
                active_d = 1'b1;
                done_d   = bit_end;
            end
            default: begin
                serial_d = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: three instances at CLKS_PER_BIT 4, 2 and 35, with a sampling receiver model on a selectable line.
module tb_uart_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       dv_a, dv_b, dv_c;
    logic [7:0] byte_a, byte_b, byte_c;
    logic       ready_a, ser_a, act_a, done_a;
    logic       ready_b, ser_b, act_b, done_b;
    logic       ready_c, ser_c, act_c, done_c;
    logic [2:0] cnt_a, cnt_b, cnt_c;

    uart_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut_a (
        .i_Clock(clk), .i_Reset(rst), .i_Tx_DV(dv_a), .i_Tx_Byte(byte_a),
        .o_Tx_Ready(ready_a), .o_Tx_Serial(ser_a), .o_Tx_Active(act_a),
        .o_Tx_Done(done_a), .o_Fifo_Count(cnt_a));

    uart_tx #(.CLKS_PER_BIT(2), .FIFO_DEPTH(4)) dut_b (
        .i_Clock(clk), .i_Reset(rst), .i_Tx_DV(dv_b), .i_Tx_Byte(byte_b),
        .o_Tx_Ready(ready_b), .o_Tx_Serial(ser_b), .o_Tx_Active(act_b),
        .o_Tx_Done(done_b), .o_Fifo_Count(cnt_b));

    uart_tx #(.CLKS_PER_BIT(35), .FIFO_DEPTH(4)) dut_c (
        .i_Clock(clk), .i_Reset(rst), .i_Tx_DV(dv_c), .i_Tx_Byte(byte_c),
        .o_Tx_Ready(ready_c), .o_Tx_Serial(ser_c), .o_Tx_Active(act_c),
        .o_Tx_Done(done_c), .o_Fifo_Count(cnt_c));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    int   sel     = 0;
    int   cpb_sel = 4;
    logic mon_en  = 1'b0;
    logic ser_sel;
    assign ser_sel = (sel == 0) ? ser_a : (sel == 1) ? ser_b : ser_c;

    logic [7:0] rx_q [$];
    int         st_q [$];
    int         stop_err = 0;
    logic [7:0] mon_b;
    int         mon_t0;

    logic [7:0] burst [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    logic [7:0] simul [4] = '{8'h3A, 8'hC4, 8'h7E, 8'hE1};
    logic [7:0] loopb [5] = '{8'h00, 8'hFF, 8'h55, 8'h80, 8'h01};

    // Receiver model: samples each bit at its centre, LSB first.
    always begin
        @(posedge clk);
        #2;
        if (mon_en && ser_sel === 1'b0) begin
            mon_t0 = cyc;
            for (int i = 0; i < 8; i++) begin
                repeat ((i == 0) ? cpb_sel + cpb_sel / 2 : cpb_sel) @(posedge clk);
                #2;
                mon_b = {ser_sel, mon_b[7:1]};
            end
            repeat (cpb_sel) @(posedge clk);
            #2;
            if (ser_sel !== 1'b1) stop_err++;
            rx_q.push_back(mon_b);
            st_q.push_back(mon_t0);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic wait_rx(input int n, input int budget);
        int k = 0;
        while (rx_q.size() < n && k < budget) begin
            tick();
            k++;
        end
        chk("rx_frame_count", 32'(rx_q.size()), 32'(n));
    endtask

    function automatic logic [7:0] rx_at(input int i);
        return (i < rx_q.size()) ? rx_q[i] : 8'hxx;
    endfunction

    function automatic int st_at(input int i);
        return (i < st_q.size()) ? st_q[i] : -100000;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        int         e;
        int         lows;

        rst = 1'b1;
        dv_a = 1'b0; dv_b = 1'b0; dv_c = 1'b0;
        byte_a = 8'h00; byte_b = 8'h00; byte_c = 8'h00;
        ticks(3);
        rst = 1'b0;
        tick();

        // Reset state of all three instances
        chk("rst_serial_a", 32'(ser_a), 1);
        chk("rst_active_a", 32'(act_a), 0);
        chk("rst_done_a",   32'(done_a), 0);
        chk("rst_ready_a",  32'(ready_a), 1);
        chk("rst_count_a",  32'(cnt_a), 0);
        chk("rst_serial_b", 32'(ser_b), 1);
        chk("rst_active_b", 32'(act_b), 0);
        chk("rst_done_b",   32'(done_b), 0);
        chk("rst_ready_b",  32'(ready_b), 1);
        chk("rst_count_b",  32'(cnt_b), 0);
        chk("rst_serial_c", 32'(ser_c), 1);
        chk("rst_active_c", 32'(act_c), 0);
        chk("rst_done_c",   32'(done_c), 0);
        chk("rst_ready_c",  32'(ready_c), 1);
        chk("rst_count_c",  32'(cnt_c), 0);

        // Single byte 0xA5: push at edge N, line falls after N+2, done after N+41
        b = 8'hA5;
        byte_a = b;
        dv_a = 1'b1;
        tick();
        dv_a = 1'b0;
        chk("a5_count_after_push", 32'(cnt_a), 1);
        chk("a5_line_k0", 32'(ser_a), 1);
        for (int k = 1; k <= 42; k++) begin
            tick();
            e = (k < 2) ? 1 : (k <= 5) ? 0 : (k <= 37) ? int'((b >> ((k - 6) / 4)) & 8'h01) : 1;
            chk($sformatf("a5_line_k%0d", k), 32'(ser_a), 32'(e));
            if (k >= 40) chk($sformatf("a5_done_k%0d", k), 32'(done_a), 32'(k == 41));
            if (k <= 2 || k >= 41) chk($sformatf("a5_active_k%0d", k), 32'(act_a), 32'(k >= 2 && k <= 41));
            if (k == 1) chk("a5_count_after_pop", 32'(cnt_a), 0);
        end

        // Burst of six pushes into a depth-4 FIFO: five sent, sixth dropped
        rx_q.delete();
        st_q.delete();
        sel = 0;
        cpb_sel = 4;
        stop_err = 0;
        mon_en = 1'b1;
        dv_a = 1'b1;
        for (int i = 0; i < 6; i++) begin
            byte_a = burst[i];
            if (i == 5) begin
                chk("burst_ready_full", 32'(ready_a), 0);
                chk("burst_count_full", 32'(cnt_a), 4);
            end
            tick();
        end
        dv_a = 1'b0;
        chk("burst_count_after_drop", 32'(cnt_a), 4);
        ticks(36);
        chk("burst_count_before_pop2", 32'(cnt_a), 4);
        chk("burst_ready_before_pop2", 32'(ready_a), 0);
        tick();
        chk("burst_count_after_pop2", 32'(cnt_a), 3);
        chk("burst_ready_after_pop2", 32'(ready_a), 1);
        wait_rx(5, 300);
        for (int i = 0; i < 5; i++) chk($sformatf("burst_byte%0d", i), 32'(rx_at(i)), 32'(burst[i]));
        for (int i = 0; i < 4; i++) chk($sformatf("burst_spacing%0d", i), 32'(st_at(i + 1) - st_at(i)), 41);
        ticks(20);
        chk("burst_no_extra_frame", 32'(rx_q.size()), 5);
        chk("burst_stop_bits", 32'(stop_err), 0);

        // Push coinciding with the IDLE pop while two bytes are queued
        rx_q.delete();
        st_q.delete();
        dv_a = 1'b1;
        for (int i = 0; i < 3; i++) begin
            byte_a = simul[i];
            tick();
        end
        dv_a = 1'b0;
        chk("simul_count_queued", 32'(cnt_a), 2);
        ticks(39);
        chk("simul_count_before", 32'(cnt_a), 2);
        byte_a = simul[3];
        dv_a = 1'b1;
        tick();
        dv_a = 1'b0;
        chk("simul_count_push_pop", 32'(cnt_a), 2);
        chk("simul_active_gap", 32'(act_a), 0);
        tick();
        chk("simul_count_after", 32'(cnt_a), 2);
        wait_rx(4, 400);
        for (int i = 0; i < 4; i++) chk($sformatf("simul_byte%0d", i), 32'(rx_at(i)), 32'(simul[i]));
        ticks(10);

        // Reset during data bit 3 with two bytes queued
        mon_en = 1'b0;
        byte_a = 8'h00;
        dv_a = 1'b1;
        ticks(3);
        dv_a = 1'b0;
        chk("midrst_count_queued", 32'(cnt_a), 2);
        ticks(17);
        chk("midrst_line_low", 32'(ser_a), 0);
        chk("midrst_active", 32'(act_a), 1);
        #3;
        rst = 1'b1;
        #1;
        chk("midrst_async_serial", 32'(ser_a), 1);
        chk("midrst_async_active", 32'(act_a), 0);
        chk("midrst_async_done", 32'(done_a), 0);
        chk("midrst_async_ready", 32'(ready_a), 1);
        chk("midrst_async_count", 32'(cnt_a), 0);
        tick();
        rst = 1'b0;
        lows = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (ser_a !== 1'b1 || act_a !== 1'b0) lows++;
        end
        chk("midrst_line_quiet", 32'(lows), 0);
        chk("midrst_count_after", 32'(cnt_a), 0);
        rx_q.delete();
        st_q.delete();
        mon_en = 1'b1;
        byte_a = 8'h96;
        dv_a = 1'b1;
        tick();
        dv_a = 1'b0;
        wait_rx(1, 100);
        chk("midrst_new_byte", 32'(rx_at(0)), 32'h96);
        ticks(30);
        chk("midrst_nothing_resent", 32'(rx_q.size()), 1);

        // Minimum CLKS_PER_BIT = 2: 0x3C, 20-cycle frame
        rx_q.delete();
        st_q.delete();
        sel = 1;
        cpb_sel = 2;
        stop_err = 0;
        ticks(2);
        byte_b = 8'h3C;
        dv_b = 1'b1;
        tick();
        dv_b = 1'b0;
        tick();
        chk("c2_line_before_start", 32'(ser_b), 1);
        tick();
        chk("c2_line_start", 32'(ser_b), 0);
        chk("c2_active_start", 32'(act_b), 1);
        ticks(18);
        chk("c2_done_early", 32'(done_b), 0);
        tick();
        chk("c2_done_last", 32'(done_b), 1);
        chk("c2_active_last", 32'(act_b), 1);
        tick();
        chk("c2_done_after", 32'(done_b), 0);
        chk("c2_active_after", 32'(act_b), 0);
        wait_rx(1, 50);
        chk("c2_byte", 32'(rx_at(0)), 32'h3C);
        chk("c2_stop_bit", 32'(stop_err), 0);

        // Loopback at CLKS_PER_BIT = 35
        rx_q.delete();
        st_q.delete();
        sel = 2;
        cpb_sel = 35;
        stop_err = 0;
        ticks(2);
        dv_c = 1'b1;
        for (int i = 0; i < 5; i++) begin
            byte_c = loopb[i];
            tick();
        end
        dv_c = 1'b0;
        chk("lb_count_queued", 32'(cnt_c), 4);
        wait_rx(5, 2200);
        for (int i = 0; i < 5; i++) chk($sformatf("lb_byte%0d", i), 32'(rx_at(i)), 32'(loopb[i]));
        for (int i = 0; i < 4; i++) chk($sformatf("lb_spacing%0d", i), 32'(st_at(i + 1) - st_at(i)), 351);
        chk("lb_stop_bits", 32'(stop_err), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
